// File: rtl/pll_clkdiv_gen.sv
// pll_clkdiv_gen: register-programmable clock divider bank with lock indicator.
// Generates NUM_CLOCKS divided clocks plus one-cycle enables from refclk, each
// with a runtime divide ratio and phase offset. Any accepted reconfiguration
// realigns every channel and drops locked until the settle time expires.
//
// Ports:
//   refclk     in   sole clock, rising edge
//   rst        in   asynchronous active-low reset
//   cfg_valid  in   configuration write request
//   cfg_ready  out  write can be accepted (not in SYNC)
//   cfg_chan   in   target channel
//   cfg_div    in   new divide ratio D (>=1)
//   cfg_phase  in   new phase offset P (<D)
//   cfg_err    out  one-cycle pulse after a rejected write
//   outclk     out  divided clock per channel
//   outclk_en  out  one-cycle enable per channel period
//   locked     out  all channels running and settled
module pll_clkdiv_gen #(
  parameter int unsigned NUM_CLOCKS  = 2,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned CH_W        = 4
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
);

  localparam int unsigned LCK_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_SYNC      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div   [NUM_CLOCKS];
  logic [DIV_W-1:0] r_phase [NUM_CLOCKS];
  logic [DIV_W-1:0] r_count [NUM_CLOCKS];
  logic [LCK_W-1:0] r_lock_cnt;
  logic             r_locked;
  logic             r_cfg_err;
  logic             w_accept;
  logic             w_valid_wr;
  logic             w_wr;
  logic             w_lock_done;

  assign cfg_ready   = (r_state != ST_SYNC);
  assign w_accept    = cfg_valid & cfg_ready;
  assign w_valid_wr  = (cfg_div != '0) && (cfg_phase < cfg_div) &&
                       (32'(cfg_chan) < NUM_CLOCKS);
  assign w_wr        = w_accept & w_valid_wr;
  assign w_lock_done = (r_lock_cnt == LCK_W'(LOCK_CYCLES - 1));
  assign locked      = r_locked;
  assign cfg_err     = r_cfg_err;

  // State register
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) r_state <= ST_SYNC;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; an accepted valid write always restarts via SYNC
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SYNC:      w_state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (w_wr)             w_state_nxt = ST_SYNC;
        else if (w_lock_done) w_state_nxt = ST_LOCKED;
      end
      ST_LOCKED:    if (w_wr) w_state_nxt = ST_SYNC;
      default:      w_state_nxt = ST_SYNC;
    endcase
  end

  // Lock counter, locked flag and reject pulse
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_locked  <= (w_state_nxt == ST_LOCKED);
      r_cfg_err <= w_accept & ~w_valid_wr;
      if (r_state == ST_SYNC)
        r_lock_cnt <= '0;
      else if (r_state == ST_WAIT_LOCK && !w_lock_done)
        r_lock_cnt <= r_lock_cnt + LCK_W'(1);
    end
  end

  // Per-channel configuration and phase counters
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_CLOCKS); i++) begin
        r_div[i]   <= DIV_W'(DEFAULT_DIV);
        r_phase[i] <= '0;
        r_count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_CLOCKS); i++) begin
        if (w_wr && (CH_W'(i) == cfg_chan)) begin
          r_div[i]   <= cfg_div;
          r_phase[i] <= cfg_phase;
        end
        // Leaving SYNC realigns every channel to its phase offset.
        // The >= compare keeps the wrap safe after D shrinks mid-count.
        if (r_state == ST_SYNC)
          r_count[i] <= r_phase[i];
        else if (r_count[i] >= r_div[i] - DIV_W'(1))
          r_count[i] <= '0;
        else
          r_count[i] <= r_count[i] + DIV_W'(1);
      end
    end
  end

  // Output decode straight from counters; forced low during SYNC
  always_comb begin
    outclk    = '0;
    outclk_en = '0;
    if (r_state != ST_SYNC) begin
      for (int i = 0; i < int'(NUM_CLOCKS); i++) begin
        if (r_div[i] == DIV_W'(1)) begin
          outclk[i]    = 1'b1;
          outclk_en[i] = 1'b1;
        end else begin
          outclk[i]    = (r_count[i] < (r_div[i] >> 1));
          outclk_en[i] = (r_count[i] == r_div[i] - DIV_W'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_pll_clkdiv_gen.sv
// Testbench for pll_clkdiv_gen: directed scenarios with literal expectations
// plus randomized writes, all checked every cycle against a timeline model.
module tb_pll_clkdiv_gen;

  localparam int unsigned NC  = 2;
  localparam int unsigned DW  = 8;
  localparam int unsigned DEF = 4;
  localparam int unsigned LC  = 16;
  localparam int unsigned CW  = 4;

  logic          refclk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan;
  logic [DW-1:0] cfg_div;
  logic [DW-1:0] cfg_phase;
  logic          cfg_err;
  logic [NC-1:0] outclk;
  logic [NC-1:0] outclk_en;
  logic          locked;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit checking = 1'b0;

  // Model: channels run as count = (P + t) mod D, t = cycles since leaving SYNC
  bit m_sync;
  int m_t;
  int m_div   [NC];
  int m_phase [NC];
  bit m_err;

  pll_clkdiv_gen #(
    .NUM_CLOCKS (NC),
    .DIV_W      (DW),
    .DEFAULT_DIV(DEF),
    .LOCK_CYCLES(LC),
    .CH_W       (CW)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .cfg_err  (cfg_err),
    .outclk   (outclk),
    .outclk_en(outclk_en),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic write(input int ch, input int d, input int p);
    cfg_valid = 1'b1;
    cfg_chan  = CW'(ch);
    cfg_div   = DW'(d);
    cfg_phase = DW'(p);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_locked(input string name, input int exp_cycles, input int mark);
    int b;
    b = 0;
    while (locked !== 1'b1 && b < 100) begin
      tick();
      b++;
    end
    chk(name, 32'(cyc - mark), 32'(exp_cycles));
  endtask

  function automatic void model_reset();
    m_sync = 1'b1;
    m_t    = 0;
    m_err  = 1'b0;
    for (int i = 0; i < int'(NC); i++) begin
      m_div[i]   = int'(DEF);
      m_phase[i] = 0;
    end
  endfunction

  always @(posedge refclk or negedge rst) begin
    bit acc;
    bit ok;
    int ch;
    if (!rst) begin
      model_reset();
    end else begin
      ch    = int'(cfg_chan);
      acc   = cfg_valid && !m_sync;
      ok    = (int'(cfg_div) >= 1) && (cfg_phase < cfg_div) && (ch < int'(NC));
      m_err = acc && !ok;
      if (m_sync) begin
        m_sync = 1'b0;
        m_t    = 0;
      end else if (acc && ok) begin
        m_div[ch]   = int'(cfg_div);
        m_phase[ch] = int'(cfg_phase);
        m_sync      = 1'b1;
      end else begin
        m_t++;
      end
    end
  end

  // Per-cycle compare against the model, sampled on the falling edge
  always @(negedge refclk) begin
    logic [NC-1:0] ec;
    logic [NC-1:0] ee;
    int d;
    int c;
    if (checking) begin
      ec = '0;
      ee = '0;
      if (!m_sync) begin
        for (int i = 0; i < int'(NC); i++) begin
          d = m_div[i];
          c = (m_phase[i] + m_t) % d;
          if (d == 1) begin
            ec[i] = 1'b1;
            ee[i] = 1'b1;
          end else begin
            ec[i] = (c < d / 2);
            ee[i] = (c == d - 1);
          end
        end
      end
      chk("model_outclk", 32'(outclk), 32'(ec));
      chk("model_outclk_en", 32'(outclk_en), 32'(ee));
      chk("model_locked", 32'(locked), 32'(!m_sync && m_t >= int'(LC)));
      chk("model_cfg_ready", 32'(cfg_ready), 32'(!m_sync));
      chk("model_cfg_err", 32'(cfg_err), 32'(m_err));
    end
  end

  initial begin
    int pat1 [4];
    int pat2 [8];
    int mark;
    pat1 = '{1, 1, 0, 0};
    pat2 = '{1, 1, 0, 0, 0, 0, 1, 1};

    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    cfg_phase = '0;
    repeat (3) tick();
    checking = 1'b1;

    // Reset state
    chk("rst_outclk", 32'(outclk), 32'd0);
    chk("rst_outclk_en", 32'(outclk_en), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);

    // Defaults: D=4 on both channels in phase, lock 17 cycles after release
    rst  = 1'b1;
    mark = cyc;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s1_outclk", 32'(outclk), (pat1[k] != 0) ? 32'd3 : 32'd0);
      chk("s1_outclk_en", 32'(outclk_en), (k == 3) ? 32'd3 : 32'd0);
    end
    wait_locked("s1_lock_time", 17, mark);

    // Reconfigure ch1 to D=8 P=2 while locked
    write(1, 8, 2);
    mark = cyc;
    chk("s2_sync_locked", 32'(locked), 32'd0);
    chk("s2_sync_outclk", 32'(outclk), 32'd0);
    chk("s2_sync_ready", 32'(cfg_ready), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("s2_ch1_outclk", 32'(outclk[1]), 32'(pat2[k]));
      chk("s2_ch1_en", 32'(outclk_en[1]), 32'(k == 5));
      chk("s2_ch0_outclk", 32'(outclk[0]), 32'(pat1[k % 4]));
    end
    wait_locked("s2_lock_time", 17, mark);

    // Rejected writes: zero divide, phase >= divide, channel out of range
    write(0, 0, 0);
    chk("s3_err_div0", 32'(cfg_err), 32'd1);
    chk("s3_locked_kept", 32'(locked), 32'd1);
    tick();
    chk("s3_err_clear", 32'(cfg_err), 32'd0);
    write(0, 5, 5);
    chk("s3_err_phase", 32'(cfg_err), 32'd1);
    chk("s3_locked_kept2", 32'(locked), 32'd1);
    write(2, 3, 0);
    chk("s3_err_chan", 32'(cfg_err), 32'd1);
    tick();
    chk("s3_err_clear2", 32'(cfg_err), 32'd0);

    // D=1 on ch0: constant high clock and enable
    write(0, 1, 0);
    chk("s4_sync_outclk", 32'(outclk), 32'd0);
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("s4_ch0_outclk", 32'(outclk[0]), 32'd1);
      chk("s4_ch0_en", 32'(outclk_en[0]), 32'd1);
      tick();
    end

    // cfg_valid held through SYNC is only taken once cfg_ready returns
    cfg_valid = 1'b1;
    cfg_chan  = CW'(1);
    cfg_div   = DW'(6);
    cfg_phase = DW'(5);
    tick();
    chk("s5_ready_sync", 32'(cfg_ready), 32'd0);
    cfg_chan  = CW'(0);
    cfg_div   = DW'(3);
    cfg_phase = DW'(1);
    tick();
    chk("s5_ready_back", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    chk("s5_second_sync", 32'(cfg_ready), 32'd0);
    // Restart five cycles into WAIT_LOCK
    repeat (5) tick();
    chk("s5_not_locked", 32'(locked), 32'd0);
    write(1, 7, 3);
    mark = cyc;
    chk("s5_resync_locked", 32'(locked), 32'd0);
    wait_locked("s5_lock_time", 17, mark);

    // Reset mid-operation after reconfiguring D=8
    write(0, 8, 0);
    wait_locked("s6_prelock", 17, cyc);
    rst = 1'b0;
    #1;
    chk("s6_rst_outclk", 32'(outclk), 32'd0);
    chk("s6_rst_en", 32'(outclk_en), 32'd0);
    chk("s6_rst_locked", 32'(locked), 32'd0);
    tick();
    tick();
    rst  = 1'b1;
    mark = cyc;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s6_outclk", 32'(outclk), (pat1[k] != 0) ? 32'd3 : 32'd0);
    end
    wait_locked("s6_lock_time", 17, mark);

    // Randomized writes and occasional resets
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      cfg_valid = ($urandom_range(0, 29) == 0);
      cfg_chan  = CW'($urandom_range(0, 2));
      cfg_div   = DW'($urandom_range(0, 9));
      cfg_phase = DW'($urandom_range(0, 9));
      tick();
    end
    cfg_valid = 1'b0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_clkdiv_gen.md
Name: pll_clkdiv_gen

Overview:
- Parametrised, register-based successor to the fixed-ratio vendor PLL wrappers.
- From one reference clock it generates NUM_CLOCKS divided clocks, each with a runtime-programmable integer divide ratio and phase offset, plus matching one-cycle clock enables.
- A lock indicator deasserts on every reconfiguration and reasserts after a programmable settle time.
- Sits between the board reference clock and downstream logic that needs related slower rates or enables (e.g. the 96/48 MHz-style pairs) without re-generating PLL IP.

Parameters:
- NUM_CLOCKS, 2, number of output channels (1..16).
- DIV_W, 8, width of divide-ratio and phase fields.
- DEFAULT_DIV, 4, divide ratio loaded into every channel at reset (1..2^DIV_W-1).
- LOCK_CYCLES, 16, refclk cycles spent in WAIT_LOCK before locked asserts (>=1).
- CH_W, 4, width of the channel-select field (2^CH_W >= NUM_CLOCKS).

Ports:
- refclk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  configuration write can be accepted.
- cfg_chan  in  CH_W  target channel.
- cfg_div  in  DIV_W  new divide ratio D.
- cfg_phase  in  DIV_W  new phase offset P.
- cfg_err  out  1  one-cycle pulse: the last write was rejected.
- outclk  out  NUM_CLOCKS  divided clock per channel.
- outclk_en  out  NUM_CLOCKS  one-cycle enable per channel period.
- locked  out  1  all channels running and settled.

Behaviour:
- Reset (rst=0, asynchronous):
  - State=SYNC, div[i]=DEFAULT_DIV, phase[i]=0, count[i]=0, lock counter=0.
  - Outputs: locked=0, cfg_ready=0, cfg_err=0, outclk=0, outclk_en=0.
- States are SYNC, WAIT_LOCK and LOCKED.
  - SYNC lasts exactly one cycle and moves to WAIT_LOCK. On that edge every count[i] loads phase[i] and the lock counter clears.
  - WAIT_LOCK: the lock counter increments each cycle. After LOCK_CYCLES cycles in WAIT_LOCK the state moves to LOCKED and locked=1 (registered).
  - LOCKED: locked stays 1 until the next accepted write or reset.
- cfg_ready=1 in WAIT_LOCK and LOCKED, 0 in SYNC. A write is accepted when cfg_valid & cfg_ready.
- Write validity:
  - Valid write requires cfg_div>=1, cfg_phase<cfg_div and cfg_chan<NUM_CLOCKS.
  - Valid write accepted at edge T: div/phase of cfg_chan update at T. Cycle T+1: state SYNC, locked=0, outputs forced 0. Cycle T+2: WAIT_LOCK with all channels restarted, so every channel realigns, not only the written one. locked=1 from cycle T+2+LOCK_CYCLES.
  - Invalid write: no register or state change. cfg_err=1 for exactly the next cycle. locked is unaffected.
- Valid write accepted during WAIT_LOCK: re-enters SYNC and restarts the full lock sequence.
- Counters (WAIT_LOCK and LOCKED): count[i] increments each cycle and wraps from D-1 to 0.
- Output decode (combinational from registered count and div; no added latency; outputs 0 in SYNC):
  - D=1: outclk[i]=1 and outclk_en[i]=1 continuously.
  - D>=2: outclk[i]=1 while count[i] < floor(D/2), otherwise 0. Even D gives 50% duty; odd D is high for floor(D/2) of D cycles.
  - D>=2: outclk_en[i]=1 in the cycle where count[i]==D-1.
- Outputs run in WAIT_LOCK; locked only qualifies them.
- Reset mid-operation: immediate return to reset values. Divide ratios revert to DEFAULT_DIV.
- Widths: count[i] is DIV_W bits. The lock counter is sized for LOCK_CYCLES with no wrap; it saturates at terminal.

Test Plan:
1. Reset release, defaults (D=4, LOCK_CYCLES=16) -> outclk pattern 1,1,0,0 repeating on both channels in phase; outclk_en high on count 3; locked rises 17 cycles after release.
2. Write chan1 D=8 P=2 while locked -> locked low next cycle; one SYNC cycle with outputs 0; ch1 count starts at 2 (outclk 0,0,0,0... actually high for counts 2,3 then low 4..7); ch0 restarts at 0; locked high 16 cycles after SYNC.
3. Write cfg_div=0, and separately cfg_phase=5 with cfg_div=5 -> cfg_err one-cycle pulse each; outclk/locked unchanged.
4. Write D=1 on chan0 -> after SYNC, outclk[0] and outclk_en[0] constantly 1.
5. Second valid write 5 cycles into WAIT_LOCK -> lock sequence restarts; locked rises 16 cycles after the new SYNC. cfg_valid held during SYNC -> not accepted until cfg_ready returns.
6. Assert rst during LOCKED after reconfiguring D=8 -> all outputs 0 immediately; after release, D back to 4 and scenario 1 timing repeats.
